// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP scan controller.
// The optional window-reuse mode is selected by LBP_WINDOW_REUSE_EN.
package lbp_pkg;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int ADDR_W    = 14;

  localparam logic [3:0] SLOT_CENTRE = 4'd4;
  localparam logic [3:0] SLOT_LAST   = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } state_t;

  // Row offset (0..2) of a row-major 3x3 window slot.
  function automatic logic [1:0] slot_row(input logic [3:0] s);
    case (s)
      4'd0, 4'd1, 4'd2: slot_row = 2'd0;
      4'd3, 4'd4, 4'd5: slot_row = 2'd1;
      default:          slot_row = 2'd2;
    endcase
  endfunction

  // Column offset (0..2) of a row-major 3x3 window slot.
  function automatic logic [1:0] slot_col(input logic [3:0] s);
    case (s)
      4'd0, 4'd3, 4'd6: slot_col = 2'd0;
      4'd1, 4'd4, 4'd7: slot_col = 2'd1;
      default:          slot_col = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/lbp_addr_gen.sv
// Row/col/slot counters and gray/result address arithmetic for the LBP scan.
// With LBP_WINDOW_REUSE_EN only the new right column is fetched past col 1.
module lbp_addr_gen
  import lbp_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv_slot,
  input  logic              adv_centre,
  output logic [3:0]        slot,
  output logic              last_slot,
  output logic              last_centre,
  output logic              shift_slot,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] centre_addr
);

  localparam logic [ADDR_W-1:0] W       = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] FIRST   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(IMG_H - 2);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] col_off;
  logic [3:0]        stride;
  logic [3:0]        next_start;

  assign last_slot   = (slot == SLOT_LAST);
  assign last_centre = (row == ROW_MAX) && (col == COL_MAX);

`ifdef LBP_WINDOW_REUSE_EN
  // Past the first column slots 2,5,8 carry the only new pixels.
  assign stride     = (col == FIRST) ? 4'd1 : 4'd3;
  assign next_start = (col == COL_MAX) ? 4'd0 : 4'd2;
  assign shift_slot = (col != FIRST) && (slot == 4'd2);
`else
  assign stride     = 4'd1;
  assign next_start = 4'd0;
  assign shift_slot = 1'b0;
`endif

  assign row_off     = row - FIRST + {{(ADDR_W-2){1'b0}}, slot_row(slot)};
  assign col_off     = col - FIRST + {{(ADDR_W-2){1'b0}}, slot_col(slot)};
  assign fetch_addr  = row_off * W + col_off;
  assign centre_addr = row * W + col;

  always_ff @(posedge clk) begin
    if (reset) begin
      row  <= FIRST;
      col  <= FIRST;
      slot <= 4'd0;
    end else if (adv_centre && !last_centre) begin
      slot <= next_start;
      if (col == COL_MAX) begin
        col <= FIRST;
        row <= row + FIRST;
      end else begin
        col <= col + FIRST;
      end
    end else if (adv_slot && !last_slot) begin
      slot <= slot + stride;
    end
  end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// LBP scan controller: walks interior centres, fetches 3x3 windows, strobes results.
// Optional window reuse (win_shift + 3-slot fetch) is enabled by LBP_WINDOW_REUSE_EN.
module lbp_scan_ctrl
  import lbp_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              win_load,
  output logic [3:0]        win_slot,
  output logic              win_shift,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              finish
);

  state_t            state;
  state_t            state_next;
  logic              adv_slot;
  logic              adv_centre;
  logic [3:0]        slot;
  logic              last_slot;
  logic              last_centre;
  logic              shift_slot;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] centre_addr;

  lbp_addr_gen #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .adv_slot   (adv_slot),
    .adv_centre (adv_centre),
    .slot       (slot),
    .last_slot  (last_slot),
    .last_centre(last_centre),
    .shift_slot (shift_slot),
    .fetch_addr (fetch_addr),
    .centre_addr(centre_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    gray_req   = 1'b0;
    win_load   = 1'b0;
    win_shift  = 1'b0;
    lbp_valid  = 1'b0;
    finish     = 1'b0;
    adv_slot   = 1'b0;
    adv_centre = 1'b0;
    case (state)
      IDLE: begin
        if (gray_ready) state_next = FETCH;
      end
      FETCH: begin
        // A stalled cycle leaves every counter and output untouched.
        if (gray_ready) begin
          gray_req  = 1'b1;
          win_load  = 1'b1;
          win_shift = shift_slot;
          adv_slot  = 1'b1;
          if (last_slot) state_next = WRITE;
        end
      end
      WRITE: begin
        lbp_valid = 1'b1;
        if (last_centre) begin
          state_next = DONE;
        end else begin
          adv_centre = 1'b1;
          state_next = FETCH;
        end
      end
      DONE: begin
        finish = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses are forced to 0 outside their strobe so idle outputs read as 0.
  assign gray_addr = gray_req  ? fetch_addr  : '0;
  assign win_slot  = win_load  ? slot        : 4'd0;
  assign lbp_addr  = lbp_valid ? centre_addr : '0;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Scoreboard bench for lbp_scan_ctrl on a small image with a window-list reference model.
module tb_lbp_scan_ctrl;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int NC    = (W - 2) * (H - 2);
  localparam int LIMIT = 5000;
`ifdef LBP_WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam int BASE_LEN = REUSE ? (H - 2) * (10 + (W - 3) * 4) : NC * 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gray_ready = 1'b0;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        win_load;
  logic [3:0]  win_slot;
  logic        win_shift;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic        finish;

  lbp_scan_ctrl #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_ready(gray_ready),
    .gray_req  (gray_req),
    .gray_addr (gray_addr),
    .win_load  (win_load),
    .win_slot  (win_slot),
    .win_shift (win_shift),
    .lbp_valid (lbp_valid),
    .lbp_addr  (lbp_addr),
    .finish    (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int slot;
    int shift;
  } fetch_t;

  fetch_t fq[$];
  int     wq[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     first_req_cyc = -1;
  int     finish_cyc = -1;
  int     wr_count = 0;
  bit     written[W*H];
  bit     drop_armed = 1'b0;
  bit     drop_trig = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gray_req"}, int'(gray_req), 0);
    chk({tag, "_gray_addr"}, int'(gray_addr), 0);
    chk({tag, "_win_load"}, int'(win_load), 0);
    chk({tag, "_win_slot"}, int'(win_slot), 0);
    chk({tag, "_win_shift"}, int'(win_shift), 0);
    chk({tag, "_lbp_valid"}, int'(lbp_valid), 0);
    chk({tag, "_lbp_addr"}, int'(lbp_addr), 0);
    chk({tag, "_finish"}, int'(finish), 0);
  endtask

  // Reference: list every window's pixel reads, then its result address.
  task automatic load_model();
    fetch_t f;
    fq.delete();
    wq.delete();
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        if (REUSE && c > 1) begin
          for (int k = 0; k < 3; k++) begin
            f.addr  = (r - 1 + k) * W + (c + 1);
            f.slot  = 3 * k + 2;
            f.shift = (k == 0) ? 1 : 0;
            fq.push_back(f);
          end
        end else begin
          for (int s = 0; s < 9; s++) begin
            f.addr  = (r - 1 + s / 3) * W + (c - 1 + s % 3);
            f.slot  = s;
            f.shift = 0;
            fq.push_back(f);
          end
        end
        wq.push_back(r * W + c);
      end
    end
  endtask

  always @(negedge clk) begin
    fetch_t f;
    int     exp_w;
    int     pr;
    int     pc;
    cyc++;
    if (!reset) begin
      if (gray_req) begin
        chk("req_needs_ready", int'(gray_ready), 1);
        chk("load_with_req", int'(win_load), 1);
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (fq.size() == 0) begin
          chk("fetch_unexpected", int'(gray_addr), -1);
        end else begin
          f = fq.pop_front();
          chk("gray_addr", int'(gray_addr), f.addr);
          chk("win_slot", int'(win_slot), f.slot);
          chk("win_shift", int'(win_shift), f.shift);
        end
        if (drop_armed && wr_count == 0 && win_slot == 4'd3) begin
          drop_armed = 1'b0;
          drop_trig  = 1'b1;
        end
      end else begin
        chk("quiet_without_req", int'(win_load) + int'(win_shift), 0);
      end
      if (lbp_valid) begin
        if (wq.size() == 0) begin
          chk("write_unexpected", int'(lbp_addr), -1);
        end else begin
          exp_w = wq.pop_front();
          chk("lbp_addr", int'(lbp_addr), exp_w);
        end
        pr = int'(lbp_addr) / W;
        pc = int'(lbp_addr) % W;
        chk("write_interior", (pr >= 1 && pr <= H - 2 && pc >= 1 && pc <= W - 2) ? 1 : 0, 1);
        if (int'(lbp_addr) < W * H) written[lbp_addr] = 1'b1;
        wr_count++;
      end
      if (finish) begin
        chk("done_quiet", int'(gray_req) + int'(lbp_valid), 0);
        if (finish_cyc < 0) finish_cyc = cyc;
      end
    end
  end

  // mode 0: always ready, 1: random stalls, 2: 5-cycle drop at slot 4 of window 1.
  task automatic run_scan(input int mode, input int abort_after);
    int stall;
    int n_written;
    stall = 0;
    reset = 1'b1;
    gray_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    load_model();
    first_req_cyc = -1;
    finish_cyc    = -1;
    wr_count      = 0;
    foreach (written[i]) written[i] = 1'b0;
    drop_armed = (mode == 2);
    drop_trig  = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < LIMIT && finish_cyc < 0; i++) begin
      if (abort_after > 0 && i == abort_after) break;
      @(posedge clk);
      #1;
      if (drop_trig) begin
        stall = 5;
        drop_trig = 1'b0;
      end
      if (stall > 0) begin
        gray_ready = 1'b0;
        stall--;
      end else if (mode == 1) begin
        gray_ready = ($urandom_range(0, 3) != 0);
      end else begin
        gray_ready = 1'b1;
      end
    end
    if (abort_after > 0) begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("midscan_rst");
    end else begin
      chk("finish_seen", (finish_cyc >= 0) ? 1 : 0, 1);
      chk("write_count", wr_count, NC);
      chk("fetch_left", fq.size(), 0);
      chk("write_left", wq.size(), 0);
      if (mode != 1) chk("scan_length", finish_cyc - first_req_cyc, BASE_LEN + ((mode == 2) ? 5 : 0));
      n_written = 0;
      foreach (written[i]) n_written += int'(written[i]);
      chk("result_coverage", n_written, NC);
      repeat (3) @(posedge clk);
      #1;
      chk("done_finish_held", int'(finish), 1);
      chk("done_no_req", int'(gray_req), 0);
      chk("done_no_valid", int'(lbp_valid), 0);
    end
  endtask

  initial begin
    run_scan(0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("done_reset_finish", int'(finish), 0);
    run_scan(2, 0);
    run_scan(1, 300);
    run_scan(1, 0);
    run_scan(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
